// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART receiver
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8-bit UART receiver, mid-bit sampling; UART_RX_PARITY_EN adds a parity bit
module uart_receive
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 dataComplete,
    output logic [DATA_BITS-1:0] data
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxd_s;
    logic                 parity_ok;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rxd),
        .dout  (rxd_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic perr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr <= 1'b0;
        end else if (state == IDLE) begin
            perr <= 1'b0;
        end else if (state == PARITY && cnt == FULL_M1) begin
            perr <= ((^shreg) ^ rxd_s) != ODD;
        end
    end

    assign parity_ok = !perr;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            data         <= '0;
            dataComplete <= 1'b0;
        end else begin
            dataComplete <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state  <= START;
                        bitcnt <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        shreg  <= {rxd_s, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        // Leaving at mid-stop-bit lets an immediately following start bit be seen
                        if (!rxd_s) begin
                            state <= WAIT_IDLE;
                        end else begin
                            state <= IDLE;
                            if (parity_ok) begin
                                data         <= shreg;
                                dataComplete <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxd_s) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - randomized self-checking bench for uart_receive against a frame-level model
module tb_uart_receive;

    localparam int CPB     = 16;
    localparam logic PODD  = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       dataComplete;
    logic [7:0] data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cyc = -1;
    logic [7:0] rx_q[$];

    uart_receive #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .dataComplete (dataComplete),
        .data         (data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && dataComplete) begin
            rx_q.push_back(data);
            pulse_cyc <= cyc;
        end
    end

    function automatic logic [7:0] got(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic logic par_bit(input logic [7:0] b);
        return (^b) ^ PODD;
    endfunction

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit(b) ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        send_bit(stop_v);
        if (!stop_v) begin
            repeat (40) @(negedge clk);
            rxd = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (dataComplete !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulse: got %b want 0", dataComplete);
        end
        tests++;
        if (data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h want 00", data);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_valid;
        int c0;
        rx_q.delete();
        pulse_cyc = -1;
        c0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 1) begin
            fails++;
            $display("FAIL valid_count: got %0d want 1", rx_q.size());
        end
        tests++;
        if (got(0) !== 8'hA5) begin
            fails++;
            $display("FAIL valid_byte: got %h want a5", got(0));
        end
        tests++;
        if (pulse_cyc < c0 || pulse_cyc - c0 > 9 * CPB + CPB / 2 + 4) begin
            fails++;
            $display("FAIL valid_latency: got %0d want <= %0d", pulse_cyc - c0, 9 * CPB + CPB / 2 + 4);
        end
        tests++;
        if (data !== 8'hA5) begin
            fails++;
            $display("FAIL valid_hold: got %h want a5", data);
        end
    endtask

    task automatic test_glitch;
        rx_q.delete();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        tests++;
        if (rx_q.size() !== 0) begin
            fails++;
            $display("FAIL glitch_nopulse: got %0d pulses want 0", rx_q.size());
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 1 || got(0) !== 8'h3C) begin
            fails++;
            $display("FAIL glitch_next: got %0d pulses byte %h want 1 byte 3c", rx_q.size(), got(0));
        end
    endtask

    task automatic test_framing;
        rx_q.delete();
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (rx_q.size() !== 0) begin
            fails++;
            $display("FAIL framing_nopulse: got %0d pulses want 0", rx_q.size());
        end
        tests++;
        if (data !== 8'h3C) begin
            fails++;
            $display("FAIL framing_hold: got %h want 3c", data);
        end
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 1 || got(0) !== 8'h81) begin
            fails++;
            $display("FAIL framing_next: got %0d pulses byte %h want 1 byte 81", rx_q.size(), got(0));
        end
    endtask

    task automatic test_back_to_back;
        rx_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d want 2", rx_q.size());
        end
        tests++;
        if (got(0) !== 8'h00 || got(1) !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_bytes: got %h %h want 00 ff", got(0), got(1));
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        b = 8'hA3;
        rx_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        rxd = b[3];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        reset = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        tests++;
        if (rx_q.size() !== 0 || data !== 8'h00) begin
            fails++;
            $display("FAIL rst_abort: got %0d pulses data %h want 0 pulses data 00", rx_q.size(), data);
        end
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 1 || got(0) !== 8'h7E) begin
            fails++;
            $display("FAIL rst_next: got %0d pulses byte %h want 1 byte 7e", rx_q.size(), got(0));
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       bad_stop;
        logic       flip;
        int         gap;
        rx_q.delete();
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            bad_stop = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            send_frame(b, !bad_stop, flip);
            if (!bad_stop && !flip) exp_q.push_back(b);
            gap = $urandom_range(0, 2) + (bad_stop ? 1 : 0);
            repeat (gap * CPB) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (got(i) !== exp_q[i]) begin
                fails++;
                $display("FAIL rand_byte[%0d]: got %h want %h", i, got(i), exp_q[i]);
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        rx_q.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 1 || got(0) !== 8'h07) begin
            fails++;
            $display("FAIL parity_good: got %0d pulses byte %h want 1 byte 07", rx_q.size(), got(0));
        end
        rx_q.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        tests++;
        if (rx_q.size() !== 0) begin
            fails++;
            $display("FAIL parity_bad: got %0d pulses want 0", rx_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_valid();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter: PARITY_ODD, default 0; 0 selects even parity, 1 selects odd; used only when UART_RX_PARITY_EN is defined.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: rxd  input  1  asynchronous serial line; idle high.
REQ-006 Port: dataComplete  output  1  one-cycle pulse when a valid byte is received.
REQ-007 Port: data  output  8  last valid received byte.

Function
REQ-008 The block SHALL pass rxd through a 2-flop synchronizer before any other logic; all timing below refers to the synchronized signal rxd_s.
REQ-009 Frame format SHALL be: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 stop bit (high).
REQ-010 States SHALL be IDLE, START, DATA, PARITY (parity build only), STOP, WAIT_IDLE.
REQ-011 IDLE: on rxd_s low, go to START and clear the bit counter.
REQ-012 START: after CLKS_PER_BIT/2 (integer division) cycles, sample rxd_s; low -> DATA; high -> false start, return to IDLE with no output change.
REQ-013 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift the samples into a shift register so that bit 0 is received first; after the 8th sample go to PARITY or STOP.
REQ-014 PARITY: sample one bit CLKS_PER_BIT cycles later and record a mismatch against the selected parity; go to STOP.
REQ-015 STOP: sample CLKS_PER_BIT cycles later; high and no parity mismatch -> load data, pulse dataComplete, go to IDLE.
REQ-016 STOP, invalid frame: stop sample low -> WAIT_IDLE, no pulse, data unchanged; parity mismatch with a high stop sample -> IDLE, no pulse, data unchanged.
REQ-017 WAIT_IDLE: remain until rxd_s high, then go to IDLE (line-break recovery).
REQ-018 dataComplete SHALL be registered and high for exactly one clock, in the cycle after the stop-bit sample; data SHALL update in the same cycle and hold until the next valid frame.
REQ-019 Returning to IDLE at mid-stop-bit SHALL allow a back-to-back start bit to be detected with no idle gap.
REQ-020 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and reset to 0 on every state change.

Reset
REQ-021 While reset is low: state=IDLE, counters=0, shift register=0, data=8'h00, dataComplete=0, synchronizer flops=1 (idle line).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block SHALL wait for a new falling edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state and parity check compiled in; frame is 11 bits.
REQ-024 Macro UART_RX_PARITY_EN undefined: no parity bit; frame is 10 bits; PARITY_ODD ignored.

Structure
REQ-025 Package uart_pkg SHALL hold the state enum typedef and constant DATA_BITS=8.
REQ-026 Sub-module uart_rx_sync (2-flop synchronizer with reset value 1) SHALL be instantiated for rxd; all other logic is in uart_receive.

Verification (CLKS_PER_BIT=16, parity off unless stated)
REQ-027 Valid byte: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> single dataComplete pulse; data=8'hA5; pulse within 9.5*16+4 clocks of the start falling edge.
REQ-028 Glitch: rxd low for 4 clocks, then high -> no dataComplete; next frame 0x3C received correctly.
REQ-029 Framing error: 0x55 with stop bit low, line held low for 40 clocks, then high -> no pulse; data keeps its previous value; next frame 0x81 received.
REQ-030 Back-to-back: frames 0x00 then 0xFF with no idle gap -> two pulses; data=8'h00, then 8'hFF.
REQ-031 Reset mid-frame: reset low during data bit 3, released, then 0x7E sent -> no pulse for the aborted frame; one pulse with data=8'h7E.
REQ-032 With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> pulse, data=8'h07; parity bit 0 -> no pulse.
